// File: rtl/arith_pkg.sv
// Shared opcode and FSM-state encodings for the arithmetic block family.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DIV  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/arith_divider.sv
// Iterative restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so the result is ready WIDTH-1 cycles later.
module arith_divider #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // One restoring step: returns {remainder, quotient} after shifting in one dividend bit.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0]       shifted;
        logic [WIDTH:0]       trial;
        logic [2*WIDTH-1:0]   res;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[WIDTH]) begin
            res = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end else begin
            res = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end
        return res;
    endfunction

    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] start_step_s;

    assign step_s       = div_step(rem_q, quo_q, dvs_q);
    assign start_step_s = div_step({WIDTH{1'b0}}, i_dividend, i_divisor);

    // Next-state: load on start, iterate while busy, pulse done on the last step.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (i_start) begin
            {rem_d, quo_d} = start_step_s;
            dvs_d          = i_divisor;
            cnt_d          = CNT_W'(WIDTH - 1);
            busy_d         = 1'b1;
        end else if (busy_q) begin
            {rem_d, quo_d} = step_s;
            cnt_d          = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q  <= {WIDTH{1'b0}};
            quo_q  <= {WIDTH{1'b0}};
            dvs_q  <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;

endmodule

// File: rtl/arith_engine.sv
// Valid/ready arithmetic engine: single-cycle add/sub/mul, iterative divide,
// results held in registered outputs until the consumer accepts them.
module arith_engine
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_value_a,
    input  logic [WIDTH-1:0] i_value_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_carry,
    output logic             o_div_by_zero
);

    logic [1:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               carry_q, carry_d;
    logic               dbz_q, dbz_d;

    logic               div_start_s;
    logic               div_busy_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;

    assign sum_s  = {1'b0, i_value_a} + {1'b0, i_value_b};
    assign diff_s = {1'b0, i_value_a} - {1'b0, i_value_b};
    assign prod_s = {{WIDTH{1'b0}}, i_value_a} * {{WIDTH{1'b0}}, i_value_b};

    arith_divider #(.WIDTH(WIDTH)) u_divider (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (div_start_s),
        .i_dividend  (i_value_a),
        .i_divisor   (i_value_b),
        .o_busy      (div_busy_s),
        .o_done      (div_done_s),
        .o_quotient  (div_quo_s),
        .o_remainder (div_rem_s)
    );

    // FSM next-state and result capture; result fields return to zero on transfer.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;
        div_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_DONE;
                    hi_d    = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                    case (i_op)
                        OP_ADD: begin
                            lo_d    = sum_s[WIDTH-1:0];
                            carry_d = sum_s[WIDTH];
                        end
                        OP_SUB: begin
                            lo_d    = diff_s[WIDTH-1:0];
                            carry_d = diff_s[WIDTH];
                        end
                        OP_MUL: begin
                            {hi_d, lo_d} = prod_s;
                        end
                        OP_DIV: begin
                            if (i_value_b == {WIDTH{1'b0}}) begin
                                lo_d  = {WIDTH{1'b1}};
                                hi_d  = i_value_a;
                                dbz_d = 1'b1;
                            end else begin
                                // Result fields stay zero while the divider runs.
                                lo_d        = {WIDTH{1'b0}};
                                state_d     = ST_DIV;
                                div_start_s = 1'b1;
                            end
                        end
                        default: begin
                            lo_d = {WIDTH{1'b0}};
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_done_s) begin
                    state_d = ST_DONE;
                    lo_d    = div_quo_s;
                    hi_d    = div_rem_s;
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                end else if (div_busy_s) begin
                    state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                    lo_d    = {WIDTH{1'b0}};
                    hi_d    = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lo_d    = {WIDTH{1'b0}};
                hi_d    = {WIDTH{1'b0}};
                carry_d = 1'b0;
                dbz_d   = 1'b0;
            end
        endcase
        valid_d = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            lo_q    <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_result_lo   = lo_q;
    assign o_result_hi   = hi_q;
    assign o_carry       = carry_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_engine.sv
// Scoreboard bench for arith_engine: directed cases, backpressure, reset abort, random ops.
module tb_arith_engine;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       carry;
        logic       dbz;
        int         lat;
    } exp_t;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [7:0] i_value_a;
    logic [7:0] i_value_b;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result_lo;
    logic [7:0] o_result_hi;
    logic       o_carry;
    logic       o_div_by_zero;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    arith_engine #(.WIDTH(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op          (i_op),
        .i_value_a     (i_value_a),
        .i_value_b     (i_value_b),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result_lo   (o_result_lo),
        .o_result_hi   (o_result_hi),
        .o_carry       (o_carry),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [8:0]  s9;
        logic [15:0] p16;
        e.lo = 8'd0; e.hi = 8'd0; e.carry = 1'b0; e.dbz = 1'b0; e.lat = 1;
        case (op)
            2'b00: begin s9 = {1'b0, a} + {1'b0, b}; e.lo = s9[7:0]; e.carry = s9[8]; end
            2'b01: begin e.lo = a - b; e.carry = (a < b); end
            2'b10: begin p16 = {8'd0, a} * {8'd0, b}; e.hi = p16[15:8]; e.lo = p16[7:0]; end
            default: begin
                if (b == 8'd0) begin
                    e.lo = 8'hFF; e.hi = a; e.dbz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = 9;
                end
            end
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] lo, input logic [7:0] hi,
                                input logic c, input logic z, input int lat);
        exp_t e;
        e.lo = lo; e.hi = hi; e.carry = c; e.dbz = z; e.lat = lat;
        return e;
    endfunction

    // Drive one request once o_ready is seen and push its expected result.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        i_op = op; i_value_a = a; i_value_b = b; i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        sb_q.push_back(e);
        // Keep requesting with different operands while busy; must be ignored.
        i_op = 2'($urandom); i_value_a = 8'($urandom); i_value_b = 8'($urandom);
        i_valid = 1'b1;
    endtask

    // Wait for the result, compare against the scoreboard, apply backpressure, transfer.
    task automatic receive(input int hold);
        exp_t e;
        int   lat;
        logic quiet;
        lat = 0;
        quiet = 1'b1;
        do begin
            @(negedge i_clk);
            lat++;
            if (o_valid !== 1'b1) begin
                if (o_ready !== 1'b0 || o_result_lo !== 8'd0 || o_result_hi !== 8'd0 ||
                    o_carry !== 1'b0 || o_div_by_zero !== 1'b0) quiet = 1'b0;
            end
        end while (o_valid !== 1'b1 && lat < 40);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            e = mk(8'd0, 8'd0, 1'b0, 1'b0, 0);
        end else begin
            e = sb_q.pop_front();
        end
        check("latency", lat, e.lat);
        check("busy_quiet", {31'd0, quiet}, 32'd1);
        for (int h = 0; h <= hold; h++) begin
            check("result_lo", {24'd0, o_result_lo}, {24'd0, e.lo});
            check("result_hi", {24'd0, o_result_hi}, {24'd0, e.hi});
            check("carry", {31'd0, o_carry}, {31'd0, e.carry});
            check("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, e.dbz});
            check("valid_held", {31'd0, o_valid}, 32'd1);
            check("ready_in_done", {31'd0, o_ready}, 32'd0);
            if (h < hold) begin
                i_value_a = 8'($urandom);
                @(negedge i_clk);
            end
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        check("valid_after_xfer", {31'd0, o_valid}, 32'd0);
        check("ready_after_xfer", {31'd0, o_ready}, 32'd1);
        check("lo_after_xfer", {24'd0, o_result_lo}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        checks = 0; errors = 0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 2'b00; i_value_a = 8'd0; i_value_b = 8'd0;
        repeat (2) @(negedge i_clk);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_lo", {24'd0, o_result_lo}, 32'd0);
        check("rst_hi", {24'd0, o_result_hi}, 32'd0);
        i_rst_n = 1'b1;

        send(2'b00, 8'd200, 8'd100, mk(8'd44, 8'd0, 1'b1, 1'b0, 1));  receive(0);
        send(2'b01, 8'd5, 8'd10, mk(8'd251, 8'd0, 1'b1, 1'b0, 1));    receive(0);
        send(2'b01, 8'd10, 8'd5, mk(8'd5, 8'd0, 1'b0, 1'b0, 1));      receive(0);
        send(2'b10, 8'd200, 8'd100, mk(8'h20, 8'h4E, 1'b0, 1'b0, 1)); receive(0);
        send(2'b10, 8'd255, 8'd255, mk(8'h01, 8'hFE, 1'b0, 1'b0, 1)); receive(0);
        send(2'b11, 8'd200, 8'd7, mk(8'd28, 8'd4, 1'b0, 1'b0, 9));    receive(0);
        send(2'b11, 8'd13, 8'd0, mk(8'd255, 8'd13, 1'b0, 1'b1, 1));   receive(0);
        send(2'b00, 8'd7, 8'd8, mk(8'd15, 8'd0, 1'b0, 1'b0, 1));      receive(3);
        send(2'b11, 8'd255, 8'd16, mk(8'd15, 8'd15, 1'b0, 1'b0, 9));  receive(3);

        // Abort a divide with reset after four cycles in DIV.
        send(2'b11, 8'd200, 8'd7, mk(8'd28, 8'd4, 1'b0, 1'b0, 9));
        i_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        check("abort_lo", {24'd0, o_result_lo}, 32'd0);
        check("abort_hi", {24'd0, o_result_hi}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(2'b00, 8'd1, 8'd1, mk(8'd2, 8'd0, 1'b0, 1'b0, 1));
        receive(0);
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            check("no_stale_valid", {31'd0, o_valid}, 32'd0);
        end

        for (int r = 0; r < 20; r++) begin
            op = 2'($urandom);
            a  = 8'($urandom);
            b  = (r % 7 == 3) ? 8'd0 : 8'($urandom);
            send(op, a, b, model(op, a, b));
            receive($urandom_range(2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
